// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared encodings for the core pipeline control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_ctrl_pkg;

  // E-stage operand forwarding mux select codes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // PC-source 2:1 mux select codes
  localparam logic PC_SEL_PLUS4  = 1'b0;
  localparam logic PC_SEL_BRANCH = 1'b1;

  // Memory-wait FSM states
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/hazard_sched_ctrl_if.sv
// Bundle of pipeline register addresses, hazard inputs and control outputs.
// Latency: n/a (wiring only).
// Backpressure: dmem_req_m/dmem_ready handshake freezes the pipeline.
interface hazard_sched_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;
  logic              reg_write_m;
  logic              reg_write_w;
  logic              load_e;
  logic              pc_src_e;
  logic              dmem_req_m;
  logic              dmem_ready;

  logic [1:0]        forward_a_e;
  logic [1:0]        forward_b_e;
  logic              pc_sel;
  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              stall_m;
  logic              stall_w;
  logic              flush_d;
  logic              flush_e;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Pipeline side: supplies stage info, consumes control
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output reg_write_m, reg_write_w, load_e, pc_src_e, dmem_req_m, dmem_ready,
    input  forward_a_e, forward_b_e, pc_sel,
    input  stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e,
    input  mem_err, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  reg_write_m, reg_write_w, load_e, pc_src_e, dmem_req_m, dmem_ready,
    output forward_a_e, forward_b_e, pc_sel,
    output stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e,
    output mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_sched_ctrl_fwd.sv
// Forwarding comparator for one E-stage source operand.
// Latency: combinational.
// Backpressure: none; valid regardless of pipeline freeze.
module fwd_sel_unit
  import core_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [REG_AW-1:0] rs_e,
  output logic [1:0]        fwd_sel
);

  // x0 is never forwarded; the younger M result wins over W
  always_comb begin
    fwd_sel = FWD_RF;
    if (rs_e != '0) begin
      if (reg_write_m && (rd_m == rs_e)) begin
        fwd_sel = FWD_M;
      end else if (reg_write_w && (rd_w == rs_e)) begin
        fwd_sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Hazard/forwarding controller: forward selects, PC select, stall/flush enables.
// Latency: controls combinational; counters, mem_err and FSM update on the next edge.
// Backpressure: M-stage access without dmem_ready freezes all five stages.
module hazard_sched_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_sched_ctrl_if.slave  bus
);

  localparam int              TW       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic lu;
  logic waiting;
  logic pc_sel, stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .reg_write_m (bus.reg_write_m),
    .rd_m        (bus.rd_m),
    .reg_write_w (bus.reg_write_w),
    .rd_w        (bus.rd_w),
    .rs_e        (bus.rs1_e),
    .fwd_sel     (bus.forward_a_e)
  );

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .reg_write_m (bus.reg_write_m),
    .rd_m        (bus.rd_m),
    .reg_write_w (bus.reg_write_w),
    .rd_w        (bus.rd_w),
    .rs_e        (bus.rs2_e),
    .fwd_sel     (bus.forward_b_e)
  );

  // Freeze is decided from the live handshake so the first waiting cycle already holds
  assign freeze = bus.dmem_req_m && !bus.dmem_ready;
  assign lu     = bus.load_e && (bus.rd_e != '0) &&
                  ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: wait in MEM_WAIT until memory answers, even past the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (bus.dmem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Outputs: freeze overrides everything, then branch beats load-use
  always_comb begin
    waiting = (state_q == MEM_WAIT);
    pc_sel  = PC_SEL_PLUS4;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (bus.pc_src_e) begin
      pc_sel  = PC_SEL_BRANCH;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Watchdog and saturating debug counters
  always_comb begin
    tmo_d       = '0;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (waiting) begin
      tmo_d = (tmo_q != TMO_LAST) ? tmo_q + TMO_ONE : tmo_q;
      if (!bus.dmem_ready && (tmo_q == TMO_LAST)) begin
        mem_err_d = 1'b1;
      end
    end
    if (stall_f && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_e && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // Watchdog, error flag and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      tmo_q       <= tmo_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_sel    = pc_sel;
  assign bus.stall_f   = stall_f;
  assign bus.stall_d   = stall_d;
  assign bus.stall_e   = stall_e;
  assign bus.stall_m   = stall_m;
  assign bus.stall_w   = stall_w;
  assign bus.flush_d   = flush_d;
  assign bus.flush_e   = flush_e;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed bench: default-parameter instance plus a small one (CNT_W=2, MEM_TIMEOUT=4).
// Both instances see identical stimulus; inputs change after edges, outputs sampled mid-cycle.
// Control vector packing: {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, pc_sel}.
module tb_hazard_sched_ctrl;
  import core_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_sched_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifa ();
  hazard_sched_ctrl_if #(.REG_AW(5), .CNT_W(2))  ifb ();

  hazard_sched_ctrl #(.REG_AW(5), .CNT_W(16), .MEM_TIMEOUT(64)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  hazard_sched_ctrl #(.REG_AW(5), .CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  assign ifb.rs1_d       = ifa.rs1_d;
  assign ifb.rs2_d       = ifa.rs2_d;
  assign ifb.rs1_e       = ifa.rs1_e;
  assign ifb.rs2_e       = ifa.rs2_e;
  assign ifb.rd_e        = ifa.rd_e;
  assign ifb.rd_m        = ifa.rd_m;
  assign ifb.rd_w        = ifa.rd_w;
  assign ifb.reg_write_m = ifa.reg_write_m;
  assign ifb.reg_write_w = ifa.reg_write_w;
  assign ifb.load_e      = ifa.load_e;
  assign ifb.pc_src_e    = ifa.pc_src_e;
  assign ifb.dmem_req_m  = ifa.dmem_req_m;
  assign ifb.dmem_ready  = ifa.dmem_ready;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {ifa.stall_f, ifa.stall_d, ifa.stall_e, ifa.stall_m, ifa.stall_w,
                  ifa.flush_d, ifa.flush_e, ifa.pc_sel};
  assign ctl_b = {ifb.stall_f, ifb.stall_d, ifb.stall_e, ifb.stall_m, ifb.stall_w,
                  ifb.flush_d, ifb.flush_e, ifb.pc_sel};

  task automatic set_idle();
    ifa.rs1_d = '0; ifa.rs2_d = '0; ifa.rs1_e = '0; ifa.rs2_e = '0;
    ifa.rd_e = '0; ifa.rd_m = '0; ifa.rd_w = '0;
    ifa.reg_write_m = 1'b0; ifa.reg_write_w = 1'b0; ifa.load_e = 1'b0;
    ifa.pc_src_e = 1'b0; ifa.dmem_req_m = 1'b0; ifa.dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    #2 rst_n = 1'b0;
    #10;
    checks++; if (ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", ifa.stall_cnt); end
    checks++; if (ifa.flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d expected 0", ifa.flush_cnt); end
    checks++; if (ifa.mem_err !== 1'b0) begin errors++; $display("FAIL rst_mem_err: got %b expected 0", ifa.mem_err); end
    checks++; if (dut_a.state_q !== RUN) begin errors++; $display("FAIL rst_state: got %b expected RUN", dut_a.state_q); end
    checks++; if (ctl_a !== 8'b00000000) begin errors++; $display("FAIL rst_ctl: got %b expected 00000000", ctl_a); end
    ifa.dmem_req_m = 1'b1;
    #1;
    checks++; if (ctl_b !== 8'b11111000) begin errors++; $display("FAIL rst_freeze: got %b expected 11111000", ctl_b); end
    set_idle();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    ifa.rd_m = 5'd5; ifa.reg_write_m = 1'b1; ifa.rd_w = 5'd5; ifa.reg_write_w = 1'b1;
    ifa.rs1_e = 5'd5; ifa.rs2_e = 5'd5;
    #1;
    checks++; if (ifa.forward_a_e !== 2'b10) begin errors++; $display("FAIL fwd_a_m_prio: got %b expected 10", ifa.forward_a_e); end
    checks++; if (ifb.forward_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_m_prio: got %b expected 10", ifb.forward_b_e); end
    ifa.rd_m = 5'd3;
    #1;
    checks++; if (ifa.forward_a_e !== 2'b01) begin errors++; $display("FAIL fwd_a_w: got %b expected 01", ifa.forward_a_e); end
    ifa.rs2_e = 5'd3;
    ifa.rs1_e = 5'd0;
    #1;
    checks++; if (ifa.forward_a_e !== 2'b00) begin errors++; $display("FAIL fwd_a_x0: got %b expected 00", ifa.forward_a_e); end
    checks++; if (ifa.forward_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_m: got %b expected 10", ifa.forward_b_e); end
    ifa.reg_write_m = 1'b0; ifa.rd_m = 5'd5; ifa.rs2_e = 5'd5;
    #1;
    checks++; if (ifa.forward_b_e !== 2'b01) begin errors++; $display("FAIL fwd_b_m_nowrite: got %b expected 01", ifa.forward_b_e); end
    ifa.reg_write_w = 1'b0;
    #1;
    checks++; if (ifa.forward_b_e !== 2'b00) begin errors++; $display("FAIL fwd_b_none: got %b expected 00", ifa.forward_b_e); end
    set_idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ifa.load_e = 1'b1; ifa.rd_e = 5'd7; ifa.rs2_d = 5'd7;
    #1;
    checks++; if (ctl_a !== 8'b11000010) begin errors++; $display("FAIL lu_ctl: got %b expected 11000010", ctl_a); end
    @(posedge clk);
    #1 set_idle();
    #1;
    checks++; if (ifa.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", ifa.stall_cnt); end
    checks++; if (ifa.flush_cnt !== 16'd1) begin errors++; $display("FAIL lu_flush_cnt: got %0d expected 1", ifa.flush_cnt); end
    checks++; if (ctl_a !== 8'b00000000) begin errors++; $display("FAIL lu_bubble_clear: got %b expected 00000000", ctl_a); end
    ifa.load_e = 1'b1; ifa.rd_e = 5'd0; ifa.rs1_d = 5'd0;
    #1;
    checks++; if (ctl_a !== 8'b00000000) begin errors++; $display("FAIL lu_rd_x0: got %b expected 00000000", ctl_a); end
    ifa.load_e = 1'b0; ifa.rd_e = 5'd7; ifa.rs1_d = 5'd7;
    #1;
    checks++; if (ctl_a !== 8'b00000000) begin errors++; $display("FAIL lu_not_load: got %b expected 00000000", ctl_a); end
    @(negedge clk) set_idle();
  endtask

  task automatic test_branch_vs_lu();
    @(negedge clk);
    ifa.load_e = 1'b1; ifa.rd_e = 5'd7; ifa.rs1_d = 5'd7; ifa.pc_src_e = 1'b1;
    #1;
    checks++; if (ctl_a !== 8'b00000111) begin errors++; $display("FAIL br_lu_ctl: got %b expected 00000111", ctl_a); end
    @(posedge clk);
    #1 set_idle();
    checks++; if (ifa.flush_cnt !== 16'd2) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 2", ifa.flush_cnt); end
    checks++; if (ifa.stall_cnt !== 16'd1) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 1", ifa.stall_cnt); end
  endtask

  task automatic test_mem_freeze();
    @(negedge clk);
    ifa.dmem_req_m = 1'b1; ifa.dmem_ready = 1'b0; ifa.pc_src_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl_a !== 8'b11111000) begin errors++; $display("FAIL frz_ctl_%0d: got %b expected 11111000", i, ctl_a); end
      @(negedge clk);
    end
    checks++; if (dut_a.state_q !== MEM_WAIT) begin errors++; $display("FAIL frz_state: got %b expected MEM_WAIT", dut_a.state_q); end
    ifa.dmem_ready = 1'b1;
    #1;
    checks++; if (ctl_a !== 8'b00000111) begin errors++; $display("FAIL frz_release: got %b expected 00000111", ctl_a); end
    @(posedge clk);
    #1;
    checks++; if (dut_a.state_q !== RUN) begin errors++; $display("FAIL frz_back_run: got %b expected RUN", dut_a.state_q); end
    set_idle();
    checks++; if (ifa.stall_cnt !== 16'd4) begin errors++; $display("FAIL frz_stall_cnt: got %0d expected 4", ifa.stall_cnt); end
    checks++; if (ifa.flush_cnt !== 16'd3) begin errors++; $display("FAIL frz_flush_cnt: got %0d expected 3", ifa.flush_cnt); end
    checks++; if (ifb.mem_err !== 1'b0) begin errors++; $display("FAIL frz_no_timeout: got %b expected 0", ifb.mem_err); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    ifa.dmem_req_m = 1'b1; ifa.dmem_ready = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 4) begin
        checks++; if (ifb.mem_err !== 1'b0) begin errors++; $display("FAIL tmo_b_early: got %b expected 0", ifb.mem_err); end
      end
      if (k == 5) begin
        checks++; if (ifb.mem_err !== 1'b1) begin errors++; $display("FAIL tmo_b_set: got %b expected 1", ifb.mem_err); end
      end
      if (k == 64) begin
        checks++; if (ifa.mem_err !== 1'b0) begin errors++; $display("FAIL tmo_a_early: got %b expected 0", ifa.mem_err); end
      end
    end
    checks++; if (ifa.mem_err !== 1'b1) begin errors++; $display("FAIL tmo_a_set: got %b expected 1", ifa.mem_err); end
    checks++; if (ctl_a !== 8'b11111000) begin errors++; $display("FAIL tmo_still_frozen: got %b expected 11111000", ctl_a); end
    ifa.dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (dut_a.state_q !== RUN) begin errors++; $display("FAIL tmo_back_run: got %b expected RUN", dut_a.state_q); end
    checks++; if (ifb.mem_err !== 1'b1) begin errors++; $display("FAIL tmo_b_sticky: got %b expected 1", ifb.mem_err); end
    checks++; if (ifa.stall_cnt !== 16'd69) begin errors++; $display("FAIL tmo_stall_cnt: got %0d expected 69", ifa.stall_cnt); end
    checks++; if (ifb.stall_cnt !== 2'd3) begin errors++; $display("FAIL tmo_b_stall_sat: got %0d expected 3", ifb.stall_cnt); end
    ifa.dmem_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ifa.mem_err, ifb.mem_err} !== 2'b00) begin errors++; $display("FAIL tmo_rst_err: got %b expected 00", {ifa.mem_err, ifb.mem_err}); end
    checks++; if (ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL tmo_rst_stall_cnt: got %0d expected 0", ifa.stall_cnt); end
    checks++; if (ifa.flush_cnt !== 16'd0) begin errors++; $display("FAIL tmo_rst_flush_cnt: got %0d expected 0", ifa.flush_cnt); end
    checks++; if (dut_a.state_q !== RUN) begin errors++; $display("FAIL tmo_rst_state: got %b expected RUN", dut_a.state_q); end
    checks++; if (ctl_a !== 8'b11111000) begin errors++; $display("FAIL tmo_rst_refreeze: got %b expected 11111000", ctl_a); end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifa.load_e = 1'b1; ifa.rd_e = 5'd9; ifa.rs1_d = 5'd9;
      @(negedge clk);
      set_idle();
      #1;
      checks++; if (ifa.stall_cnt !== 16'(i + 1)) begin errors++; $display("FAIL sat_a_%0d: got %0d expected %0d", i, ifa.stall_cnt, i + 1); end
      checks++; if (ifb.stall_cnt !== 2'((i >= 2) ? 3 : i + 1)) begin errors++; $display("FAIL sat_b_stall_%0d: got %0d expected %0d", i, ifb.stall_cnt, (i >= 2) ? 3 : i + 1); end
      checks++; if (ifb.flush_cnt !== 2'((i >= 2) ? 3 : i + 1)) begin errors++; $display("FAIL sat_b_flush_%0d: got %0d expected %0d", i, ifb.flush_cnt, (i >= 2) ? 3 : i + 1); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lu();
    test_mem_freeze();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage RISC-V core. It computes the select codes for the E-stage operand forwarding muxes and the PC-source 2:1 mux, and generates stall/flush enables for the pipeline registers. A small FSM freezes the whole pipeline while a data-memory access waits on a ready handshake, with a timeout watchdog and stall/flush event counters for debug.

Parameters:
REG_AW, 5, register-address width.
CNT_W, 16, width of the stall and flush event counters; counters saturate.
MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles before mem_err is raised.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rs1_d, rs2_d  in  REG_AW  source registers of the instruction in D.
rs1_e, rs2_e, rd_e  in  REG_AW  source and destination registers of the instruction in E.
rd_m, rd_w  in  REG_AW  destination registers in M and W.
reg_write_m, reg_write_w  in  1  register-write enables in M and W.
load_e  in  1  instruction in E is a load.
pc_src_e  in  1  branch/jump taken, resolved in E.
dmem_req_m  in  1  M-stage data-memory access valid.
dmem_ready  in  1  data memory completes the access this cycle.
forward_a_e, forward_b_e  out  2  00 = register file, 10 = M result, 01 = W result.
pc_sel  out  1  PC mux select: 1 = branch target, 0 = PC+4.
stall_f, stall_d, stall_e, stall_m, stall_w  out  1  pipeline-register hold enables.
flush_d, flush_e  out  1  pipeline-register clear enables.
mem_err  out  1  sticky memory-timeout flag.
stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset (async, rst_n=0): FSM goes to RUN; timeout counter, stall_cnt, flush_cnt and mem_err clear to 0. Combinational outputs evaluate with state=RUN.
- Forwarding (combinational, valid in every state): forward_a_e=10 if reg_write_m and rd_m==rs1_e and rs1_e!=0. Otherwise it is 01 if reg_write_w and rd_w==rs1_e and rs1_e!=0. Otherwise it is 00. M has priority over W. forward_b_e follows the same rules using rs2_e.
- Load-use hazard: lu = load_e and rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d).
- FSM states:
  - RUN: if dmem_req_m and not dmem_ready, go to MEM_WAIT next cycle. The current cycle already freezes (see freeze rule).
  - MEM_WAIT: stay while not dmem_ready. On dmem_ready, go to RUN next cycle.
- freeze = dmem_req_m and not dmem_ready, in either state. While freeze: all five stall_* = 1, flush_d = flush_e = 0, pc_sel = 0. A taken branch in E is therefore held and redirects on the first unfrozen cycle.
- When not frozen:
  - pc_sel = pc_src_e.
  - If pc_src_e: flush_d = flush_e = 1 and stall_f = stall_d = 0. The branch dominates a simultaneous load-use.
  - Else if lu: stall_f = stall_d = 1 and flush_e = 1, for exactly one cycle. The bubble clears lu on the next cycle.
  - stall_e, stall_m, stall_w are 0.
- Timeout: a counter increments each cycle in MEM_WAIT and clears in RUN. When it reaches MEM_TIMEOUT-1 while still waiting, mem_err is set on the next edge. mem_err stays set until reset. The FSM keeps waiting.
- Counters:
  - stall_cnt increments on each cycle with stall_f=1.
  - flush_cnt increments on each cycle with flush_e=1.
  - Both saturate at all-ones.
- Reset asserted mid-MEM_WAIT returns to RUN immediately. dmem_req_m/dmem_ready may still re-freeze the pipeline combinationally.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - forwarding encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - PC_SEL_PLUS4=0 and PC_SEL_BRANCH=1;
  - FSM state enum {RUN, MEM_WAIT}.
- One natural sub-module: fwd_sel_unit, the pure combinational forwarding comparator, instantiated once per E-stage operand.

Test Plan:
1. rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> forward_a_e=10. With rd_m=3 -> 01. With rs1_e=0 -> 00.
2. load_e=1, rd_e=7, rs2_d=7 -> for one cycle stall_f=stall_d=flush_e=1; stall_cnt=1 and flush_cnt=1 after that edge.
3. Load-use and pc_src_e=1 in the same cycle -> pc_sel=1, flush_d=flush_e=1, stall_f=0.
4. dmem_req_m=1, dmem_ready=0 for 3 cycles with pc_src_e=1 -> all stall_*=1 and pc_sel=0 for 3 cycles. Then dmem_ready=1 -> pc_sel=1, flush_d=1, FSM returns to RUN.
5. MEM_TIMEOUT=4 with dmem_ready held 0 -> mem_err rises after cycle 4 of MEM_WAIT and stays 1 after dmem_ready. Pulsing rst_n low mid-wait clears mem_err and the counters immediately.
6. CNT_W=2 with 5 load-use bubbles -> stall_cnt saturates at 3.
